// File: rtl/tcp_session_pkg.sv
// Shared types for the multi-connection TCP session table: the lookup tuple,
// the per-slot entry, TCP flag bit positions and the sequence-advance rule.
package tcp_session_pkg;

  localparam int TCP_FLAG_FIN = 0;
  localparam int TCP_FLAG_SYN = 1;
  localparam int TCP_FLAG_RST = 2;

  typedef struct packed {
    logic [31:0] remote_ip;
    logic [15:0] remote_port;
    logic [15:0] local_port;
  } session_key_t;

  typedef struct packed {
    logic         active;
    session_key_t key;
    logic [31:0]  rcv_nxt;
    logic [31:0]  idle;
  } session_entry_t;

  // SYN and FIN each consume one sequence number on top of the payload bytes.
  function automatic logic [31:0] seq_advance(input logic [31:0] seq,
                                              input logic [15:0] len,
                                              input logic        syn,
                                              input logic        fin);
    return seq + {16'd0, len} + {31'd0, syn} + {31'd0, fin};
  endfunction

endpackage

// File: rtl/tcp_session_match.sv
// Combinational matcher: per-slot tuple compare for lookups and alloc duplicate
// detection, hit one-hot to id, and lowest-index free slot selection.
module tcp_session_match
  import tcp_session_pkg::*;
#(
  parameter int NUM_SESSIONS = 4,
  parameter int ID_W         = 2
) (
  input  logic [NUM_SESSIONS-1:0] active,
  input  session_key_t            keys [NUM_SESSIONS],
  input  session_key_t            meta_key,
  input  session_key_t            alloc_key,
  output logic [NUM_SESSIONS-1:0] hit_onehot,
  output logic                    hit,
  output logic [ID_W-1:0]         hit_id,
  output logic                    alloc_dup,
  output logic                    free_avail,
  output logic [ID_W-1:0]         free_slot
);

  // Duplicate tuples are refused at alloc time, so at most one slot can hit.
  always_comb begin
    hit_onehot = {NUM_SESSIONS{1'b0}};
    alloc_dup  = 1'b0;
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      hit_onehot[i] = active[i] & (keys[i] == meta_key);
      alloc_dup     = alloc_dup | (active[i] & (keys[i] == alloc_key));
    end
  end

  always_comb begin
    hit_id = {ID_W{1'b0}};
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      hit_id = hit_id | (hit_onehot[i] ? ID_W'(i) : {ID_W{1'b0}});
    end
  end

  assign hit = |hit_onehot;

  // Scan high to low so the lowest inactive index is the last one written.
  always_comb begin
    free_avail = ~&active;
    free_slot  = {ID_W{1'b0}};
    for (int i = NUM_SESSIONS - 1; i >= 0; i--) begin
      free_slot = active[i] ? free_slot : ID_W'(i);
    end
  end

endmodule

// File: rtl/tcp_session_table.sv
// Multi-connection TCP session table: tuple lookup with in-order detection,
// per-session expected sequence tracking, alloc/free and idle-timeout retirement.
module tcp_session_table
  import tcp_session_pkg::*;
#(
  parameter int  NUM_SESSIONS  = 4,
  parameter int  TIMEOUT_TICKS = 1000,
  localparam int ID_W          = $clog2(NUM_SESSIONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  input  logic [31:0]             alloc_remote_ip,
  input  logic [15:0]             alloc_remote_port,
  input  logic [15:0]             alloc_local_port,
  input  logic [31:0]             alloc_rcv_nxt,
  output logic                    alloc_done,
  output logic                    alloc_fail,
  output logic [ID_W-1:0]         alloc_id,
  input  logic                    free_valid,
  input  logic [ID_W-1:0]         free_id,
  input  logic                    meta_valid,
  output logic                    meta_ready,
  input  logic [31:0]             meta_src_ip,
  input  logic [15:0]             meta_src_port,
  input  logic [15:0]             meta_dst_port,
  input  logic [31:0]             meta_seq_num,
  input  logic [15:0]             meta_payload_len,
  input  logic [7:0]              meta_flags,
  output logic                    lkp_valid,
  input  logic                    lkp_ready,
  output logic                    lkp_hit,
  output logic [ID_W-1:0]         lkp_id,
  output logic                    lkp_in_order,
  output logic [31:0]             lkp_expected_seq,
  output logic                    timeout_valid,
  output logic [ID_W-1:0]         timeout_id,
  output logic [NUM_SESSIONS-1:0] active_mask
);

  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_TICKS);

  session_entry_t          entry_r [NUM_SESSIONS];
  session_key_t            key_s   [NUM_SESSIONS];
  session_key_t            meta_key_s;
  session_key_t            alloc_key_s;
  logic [NUM_SESSIONS-1:0] active_s;
  logic [NUM_SESSIONS-1:0] hit_oh_s;
  logic [NUM_SESSIONS-1:0] hit_acc_oh_s;
  logic [NUM_SESSIONS-1:0] free_oh_s;
  logic [NUM_SESSIONS-1:0] grant_oh_s;
  logic [NUM_SESSIONS-1:0] sat_s;
  logic [NUM_SESSIONS-1:0] retire_oh_s;
  logic                    meta_hit_s;
  logic [ID_W-1:0]         meta_hit_id_s;
  logic                    alloc_dup_s;
  logic                    free_avail_s;
  logic [ID_W-1:0]         free_slot_s;
  logic                    meta_acc_s;
  logic                    meta_in_order_s;
  logic [31:0]             meta_exp_s;
  logic                    alloc_ok_s;
  logic                    retire_s;
  logic [ID_W-1:0]         retire_id_s;
  logic                    unused_flags_s;

  assign meta_key_s     = {meta_src_ip, meta_src_port, meta_dst_port};
  assign alloc_key_s    = {alloc_remote_ip, alloc_remote_port, alloc_local_port};
  assign unused_flags_s = ^meta_flags[7:3];
  assign alloc_ready    = 1'b1;
  assign meta_ready     = ~lkp_valid | lkp_ready;
  assign meta_acc_s     = meta_valid & meta_ready;
  assign active_mask    = active_s;

  // Flatten entry registers into the views the matcher needs.
  always_comb begin
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      key_s[i]    = entry_r[i].key;
      active_s[i] = entry_r[i].active;
    end
  end

  tcp_session_match #(
    .NUM_SESSIONS (NUM_SESSIONS),
    .ID_W         (ID_W)
  ) u_match (
    .active     (active_s),
    .keys       (key_s),
    .meta_key   (meta_key_s),
    .alloc_key  (alloc_key_s),
    .hit_onehot (hit_oh_s),
    .hit        (meta_hit_s),
    .hit_id     (meta_hit_id_s),
    .alloc_dup  (alloc_dup_s),
    .free_avail (free_avail_s),
    .free_slot  (free_slot_s)
  );

  assign meta_exp_s      = meta_hit_s ? entry_r[meta_hit_id_s].rcv_nxt : 32'd0;
  assign meta_in_order_s = meta_hit_s & (meta_seq_num == meta_exp_s);
  assign alloc_ok_s      = alloc_valid & free_avail_s & ~alloc_dup_s;

  // Per-slot event decode; a slot being hit or freed is never retired this cycle.
  always_comb begin
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      free_oh_s[i]    = free_valid & (free_id == ID_W'(i));
      grant_oh_s[i]   = alloc_ok_s & (free_slot_s == ID_W'(i));
      hit_acc_oh_s[i] = meta_acc_s & hit_oh_s[i];
      sat_s[i]        = entry_r[i].active & (entry_r[i].idle == TMO_LIMIT)
                        & ~hit_acc_oh_s[i] & ~free_oh_s[i];
    end
  end

  // Timeout arbiter: lowest saturated index retires, the rest wait their turn.
  always_comb begin
    retire_s    = |sat_s;
    retire_id_s = {ID_W{1'b0}};
    retire_oh_s = {NUM_SESSIONS{1'b0}};
    for (int i = NUM_SESSIONS - 1; i >= 0; i--) begin
      retire_id_s = sat_s[i] ? ID_W'(i) : retire_id_s;
    end
    for (int i = 0; i < NUM_SESSIONS; i++) begin
      retire_oh_s[i] = retire_s & (retire_id_s == ID_W'(i));
    end
  end

  // Entry state: free > alloc > hit > retire > tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SESSIONS; i++) begin
        entry_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SESSIONS; i++) begin
        if (free_oh_s[i]) begin
          entry_r[i].active <= 1'b0;
          entry_r[i].idle   <= 32'd0;
        end else if (grant_oh_s[i]) begin
          entry_r[i] <= '{active: 1'b1, key: alloc_key_s, rcv_nxt: alloc_rcv_nxt, idle: 32'd0};
        end else if (hit_acc_oh_s[i]) begin
          if (meta_flags[TCP_FLAG_RST]) begin
            entry_r[i].active <= 1'b0;
          end
          if (meta_in_order_s) begin
            entry_r[i].rcv_nxt <= seq_advance(entry_r[i].rcv_nxt, meta_payload_len,
                                              meta_flags[TCP_FLAG_SYN], meta_flags[TCP_FLAG_FIN]);
          end
          entry_r[i].idle <= 32'd0;
        end else if (retire_oh_s[i]) begin
          entry_r[i].active <= 1'b0;
          entry_r[i].idle   <= 32'd0;
        end else if (tick && entry_r[i].active && (entry_r[i].idle != TMO_LIMIT)) begin
          entry_r[i].idle <= entry_r[i].idle + 32'd1;
        end
      end
    end
  end

  // Lookup result register: loads on acceptance, holds until consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lkp_valid        <= 1'b0;
      lkp_hit          <= 1'b0;
      lkp_id           <= {ID_W{1'b0}};
      lkp_in_order     <= 1'b0;
      lkp_expected_seq <= 32'd0;
    end else if (meta_acc_s) begin
      lkp_valid        <= 1'b1;
      lkp_hit          <= meta_hit_s;
      lkp_id           <= meta_hit_id_s;
      lkp_in_order     <= meta_in_order_s;
      lkp_expected_seq <= meta_exp_s;
    end else if (lkp_ready) begin
      lkp_valid <= 1'b0;
    end
  end

  // Alloc response and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_done    <= 1'b0;
      alloc_fail    <= 1'b0;
      alloc_id      <= {ID_W{1'b0}};
      timeout_valid <= 1'b0;
      timeout_id    <= {ID_W{1'b0}};
    end else begin
      alloc_done    <= alloc_valid;
      alloc_fail    <= alloc_valid & ~alloc_ok_s;
      alloc_id      <= alloc_ok_s ? free_slot_s : {ID_W{1'b0}};
      timeout_valid <= retire_s;
      timeout_id    <= retire_id_s;
    end
  end

endmodule

// File: tb/tb_tcp_session_table.sv
// Self-checking bench for tcp_session_table: directed scenarios followed by
// randomized traffic, all compared against a behavioural table model.
module tb_tcp_session_table;

  localparam int NS  = 4;
  localparam int TMO = 3;

  logic        clk = 1'b0;
  logic        rst_n, tick;
  logic        alloc_valid, alloc_ready;
  logic [31:0] alloc_remote_ip;
  logic [15:0] alloc_remote_port, alloc_local_port;
  logic [31:0] alloc_rcv_nxt;
  logic        alloc_done, alloc_fail;
  logic [1:0]  alloc_id;
  logic        free_valid;
  logic [1:0]  free_id;
  logic        meta_valid, meta_ready;
  logic [31:0] meta_src_ip;
  logic [15:0] meta_src_port, meta_dst_port;
  logic [31:0] meta_seq_num;
  logic [15:0] meta_payload_len;
  logic [7:0]  meta_flags;
  logic        lkp_valid, lkp_ready, lkp_hit;
  logic [1:0]  lkp_id;
  logic        lkp_in_order;
  logic [31:0] lkp_expected_seq;
  logic        timeout_valid;
  logic [1:0]  timeout_id;
  logic [3:0]  active_mask;

  tcp_session_table #(.NUM_SESSIONS(NS), .TIMEOUT_TICKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_remote_ip(alloc_remote_ip), .alloc_remote_port(alloc_remote_port),
    .alloc_local_port(alloc_local_port), .alloc_rcv_nxt(alloc_rcv_nxt),
    .alloc_done(alloc_done), .alloc_fail(alloc_fail), .alloc_id(alloc_id),
    .free_valid(free_valid), .free_id(free_id),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .meta_src_ip(meta_src_ip), .meta_src_port(meta_src_port), .meta_dst_port(meta_dst_port),
    .meta_seq_num(meta_seq_num), .meta_payload_len(meta_payload_len), .meta_flags(meta_flags),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_hit(lkp_hit), .lkp_id(lkp_id),
    .lkp_in_order(lkp_in_order), .lkp_expected_seq(lkp_expected_seq),
    .timeout_valid(timeout_valid), .timeout_id(timeout_id), .active_mask(active_mask)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference table and expected registered outputs.
  bit          m_act  [NS];
  logic [31:0] m_ip   [NS];
  logic [15:0] m_rp   [NS];
  logic [15:0] m_lp   [NS];
  logic [31:0] m_ex   [NS];
  int          m_idle [NS];
  bit          e_lv, e_lh, e_lio, e_ad, e_af, e_tv;
  int          e_lid, e_aid, e_tid;
  logic [31:0] e_lexp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int m_find(input logic [31:0] ip, input logic [15:0] rp, input logic [15:0] lp);
    int r = -1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (m_act[i] && m_ip[i] == ip && m_rp[i] == rp && m_lp[i] == lp) r = i;
    end
    return r;
  endfunction

  function automatic logic [3:0] m_mask();
    logic [3:0] m = 4'd0;
    for (int i = 0; i < NS; i++) m[i] = m_act[i];
    return m;
  endfunction

  task automatic clear_inputs();
    tick = 1'b0; alloc_valid = 1'b0; free_valid = 1'b0; meta_valid = 1'b0;
    free_id = 2'd0; meta_flags = 8'd0; meta_payload_len = 16'd0;
  endtask

  task automatic check_outputs();
    chk("alloc_done", 32'(alloc_done), 32'(e_ad));
    chk("alloc_fail", 32'(alloc_fail), 32'(e_af));
    chk("alloc_id", 32'(alloc_id), 32'(e_aid));
    chk("lkp_valid", 32'(lkp_valid), 32'(e_lv));
    chk("lkp_hit", 32'(lkp_hit), 32'(e_lh));
    chk("lkp_id", 32'(lkp_id), 32'(e_lid));
    chk("lkp_in_order", 32'(lkp_in_order), 32'(e_lio));
    chk("lkp_expected_seq", lkp_expected_seq, e_lexp);
    chk("timeout_valid", 32'(timeout_valid), 32'(e_tv));
    chk("timeout_id", 32'(timeout_id), 32'(e_tid));
    chk("active_mask", 32'(active_mask), 32'(m_mask()));
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) begin
      m_act[i] = 1'b0; m_ip[i] = 32'd0; m_rp[i] = 16'd0; m_lp[i] = 16'd0;
      m_ex[i] = 32'd0; m_idle[i] = 0;
    end
    e_lv = 1'b0; e_lh = 1'b0; e_lio = 1'b0; e_ad = 1'b0; e_af = 1'b0; e_tv = 1'b0;
    e_lid = 0; e_aid = 0; e_tid = 0; e_lexp = 32'd0;
    check_outputs();
    chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("reset_meta_ready", 32'(meta_ready), 32'd1);
  endtask

  // One clock: predict from the pre-edge table, clock, then advance the model.
  task automatic cycle();
    int hid, fs, fi, rt;
    bit dup, acc, aok, io;
    hid = m_find(meta_src_ip, meta_src_port, meta_dst_port);
    dup = m_find(alloc_remote_ip, alloc_remote_port, alloc_local_port) >= 0;
    fs = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_act[i]) fs = i;
    aok = alloc_valid && !dup && fs >= 0;
    fi  = free_valid ? int'(free_id) : -1;
    acc = meta_valid && (!e_lv || lkp_ready);
    io  = hid >= 0 && meta_seq_num == m_ex[hid];
    rt  = -1;
    for (int i = NS - 1; i >= 0; i--) begin
      if (m_act[i] && m_idle[i] >= TMO && !(acc && hid == i) && fi != i) rt = i;
    end
    #1;
    chk("meta_ready", 32'(meta_ready), 32'(!e_lv || lkp_ready));
    chk("alloc_ready", 32'(alloc_ready), 32'd1);
    @(posedge clk); #1;
    if (acc) begin
      e_lv = 1'b1; e_lh = hid >= 0; e_lid = (hid >= 0) ? hid : 0;
      e_lexp = (hid >= 0) ? m_ex[hid] : 32'd0; e_lio = io;
    end else if (lkp_ready) begin
      e_lv = 1'b0;
    end
    e_ad = alloc_valid; e_af = alloc_valid && !aok; e_aid = aok ? fs : 0;
    e_tv = rt >= 0; e_tid = (rt >= 0) ? rt : 0;
    for (int i = 0; i < NS; i++) begin
      if (fi == i) begin
        m_act[i] = 1'b0; m_idle[i] = 0;
      end else if (aok && fs == i) begin
        m_act[i] = 1'b1; m_ip[i] = alloc_remote_ip; m_rp[i] = alloc_remote_port;
        m_lp[i] = alloc_local_port; m_ex[i] = alloc_rcv_nxt; m_idle[i] = 0;
      end else if (acc && hid == i) begin
        if (meta_flags[2]) m_act[i] = 1'b0;
        if (io) m_ex[i] = m_ex[i] + 32'(meta_payload_len) + 32'(meta_flags[1]) + 32'(meta_flags[0]);
        m_idle[i] = 0;
      end else if (rt == i) begin
        m_act[i] = 1'b0; m_idle[i] = 0;
      end else if (tick && m_act[i] && m_idle[i] < TMO) begin
        m_idle[i]++;
      end
    end
    check_outputs();
  endtask

  task automatic do_alloc(input logic [31:0] ip, input logic [15:0] rp, input logic [15:0] lp,
                          input logic [31:0] nxt);
    alloc_valid = 1'b1; alloc_remote_ip = ip; alloc_remote_port = rp;
    alloc_local_port = lp; alloc_rcv_nxt = nxt;
    cycle();
    alloc_valid = 1'b0;
  endtask

  task automatic do_meta(input logic [31:0] ip, input logic [15:0] sp, input logic [31:0] seq,
                         input logic [15:0] len, input logic [7:0] flags);
    meta_valid = 1'b1; meta_src_ip = ip; meta_src_port = sp; meta_dst_port = 16'd80;
    meta_seq_num = seq; meta_payload_len = len; meta_flags = flags;
    cycle();
    meta_valid = 1'b0; meta_flags = 8'd0;
  endtask

  task automatic do_free(input logic [1:0] id);
    free_valid = 1'b1; free_id = id;
    cycle();
    free_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] seq_a, seq_b;
    int k, s;
    lkp_ready = 1'b1;
    alloc_remote_ip = 32'd0; alloc_remote_port = 16'd0; alloc_local_port = 16'd0;
    alloc_rcv_nxt = 32'd0; meta_src_ip = 32'd0; meta_src_port = 16'd0;
    meta_dst_port = 16'd0; meta_seq_num = 32'd0;
    do_reset();

    // 1: first session, in-order segment
    do_alloc(32'h0A000002, 16'd5000, 16'd80, 32'd100);
    chk("t1_alloc_ok", 32'({alloc_done, alloc_fail, alloc_id}), 32'b1000);
    do_meta(32'h0A000002, 16'd5000, 32'd100, 16'd20, 8'h00);
    chk("t1_lkp", 32'({lkp_hit, lkp_id, lkp_in_order}), 32'b1001);
    chk("t1_exp", lkp_expected_seq, 32'd100);

    // 2: out-of-order, then SYN|FIN each consume one
    do_meta(32'h0A000002, 16'd5000, 32'd200, 16'd10, 8'h00);
    chk("t2_ooo", 32'({lkp_hit, lkp_in_order}), 32'b10);
    chk("t2_exp120", lkp_expected_seq, 32'd120);
    do_meta(32'h0A000002, 16'd5000, 32'd120, 16'd0, 8'h03);
    chk("t2_synfin_io", 32'(lkp_in_order), 32'd1);
    do_meta(32'h0A000002, 16'd5000, 32'd122, 16'd0, 8'h00);
    chk("t2_exp122", lkp_expected_seq, 32'd122);

    // 3: fill, overflow, free/realloc, duplicate
    for (int i = 1; i < 4; i++) do_alloc(32'h0A000002 + 32'(i), 16'(5000 + i), 16'd80, 32'(1000 * i));
    chk("t3_full_mask", 32'(active_mask), 32'hF);
    do_alloc(32'h0A000006, 16'd5004, 16'd80, 32'd7);
    chk("t3_full_fail", 32'({alloc_done, alloc_fail}), 32'b11);
    do_free(2'd2);
    do_alloc(32'h0A000004, 16'd5002, 16'd80, 32'd2000);
    chk("t3_realloc_id", 32'({alloc_fail, alloc_id}), 32'b010);
    do_alloc(32'h0A000002, 16'd5000, 16'd80, 32'd9);
    chk("t3_dup_fail", 32'(alloc_fail), 32'd1);

    // 4: sequence wrap
    do_free(2'd3);
    do_alloc(32'h0A000007, 16'd5005, 16'd80, 32'hFFFFFFF0);
    chk("t4_alloc_id", 32'(alloc_id), 32'd3);
    do_meta(32'h0A000007, 16'd5005, 32'hFFFFFFF0, 16'd32, 8'h00);
    do_meta(32'h0A000007, 16'd5005, 32'h00000010, 16'd0, 8'h00);
    chk("t4_wrap", 32'({lkp_hit, lkp_in_order}), 32'b11);
    chk("t4_wrap_exp", lkp_expected_seq, 32'h00000010);

    // 5: idle timeout; slot 2 is hit on the saturating tick and survives
    tick = 1'b1; cycle(); cycle(); tick = 1'b0;
    do_meta(32'h0A000002, 16'd5000, 32'd0, 16'd0, 8'h00);
    tick = 1'b1;
    do_meta(32'h0A000004, 16'd5002, 32'd0, 16'd0, 8'h00);
    tick = 1'b0;
    cycle();
    chk("t5_tmo1", 32'({timeout_valid, timeout_id}), 32'b101);
    cycle();
    chk("t5_tmo3", 32'({timeout_valid, timeout_id}), 32'b111);
    cycle();
    chk("t5_tmo_done", 32'(timeout_valid), 32'd0);
    chk("t5_mask", 32'(active_mask), 32'b0101);

    // 6: backpressure holds the result and stalls the next segment
    lkp_ready = 1'b0;
    seq_a = m_ex[0];
    do_meta(32'h0A000002, 16'd5000, seq_a, 16'd5, 8'h00);
    seq_b = seq_a + 32'd5;
    meta_valid = 1'b1; meta_seq_num = seq_b; meta_payload_len = 16'd5;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("t6_stall", 32'(meta_ready), 32'd0);
      chk("t6_hold", lkp_expected_seq, seq_a);
      chk("t6_hold_io", 32'(lkp_in_order), 32'd1);
    end
    lkp_ready = 1'b1;
    cycle();
    meta_valid = 1'b0;
    chk("t6_second", 32'({lkp_valid, lkp_in_order}), 32'b11);
    chk("t6_second_exp", lkp_expected_seq, seq_b);
    cycle();
    chk("t6_drain", 32'(lkp_valid), 32'd0);

    // Reset with a result pending discards it
    lkp_ready = 1'b0;
    do_meta(32'h0A000002, 16'd5000, 32'd0, 16'd0, 8'h00);
    do_reset();
    chk("rst_mid_lkp", 32'(lkp_valid), 32'd0);

    // Randomized traffic over a small tuple pool
    for (int n = 0; n < 600; n++) begin
      k = int'($urandom_range(0, 5));
      alloc_valid = $urandom_range(0, 9) < 3;
      alloc_remote_ip = 32'h0A000100 + 32'(k); alloc_remote_port = 16'(6000 + k);
      alloc_local_port = 16'd443; alloc_rcv_nxt = $urandom;
      free_valid = $urandom_range(0, 9) == 0;
      free_id = 2'($urandom_range(0, 3));
      k = int'($urandom_range(0, 5));
      meta_valid = $urandom_range(0, 9) < 6;
      meta_src_ip = 32'h0A000100 + 32'(k); meta_src_port = 16'(6000 + k);
      meta_dst_port = 16'd443;
      s = m_find(meta_src_ip, meta_src_port, meta_dst_port);
      meta_seq_num = (s >= 0 && $urandom_range(0, 3) != 0) ? m_ex[s] : $urandom;
      meta_payload_len = 16'($urandom_range(0, 1500));
      meta_flags = 8'($urandom_range(0, 3)) | (($urandom_range(0, 15) == 0) ? 8'h04 : 8'h00);
      tick = $urandom_range(0, 2) == 0;
      lkp_ready = $urandom_range(0, 9) < 7;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
